// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier feeding the MulFile product register, one bit per clock.
// Optional signed operation is enabled by defining MUL_SIGNED_EN.
module seq_multiplier #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  input  logic               Signed,
  output logic               Busy,
  output logic               MulWrite,
  output logic [2*WIDTH-1:0] WriteMul
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] write_mul_q, write_mul_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   op_a_mag, op_b_mag;
  logic               sign_in;
  logic               last_iter;

`ifdef MUL_SIGNED_EN
  // Magnitudes fit unsigned even for the most negative operand.
  always_comb begin
    op_a_mag = (Signed && OpA[WIDTH-1]) ? (~OpA + 1'b1) : OpA;
    op_b_mag = (Signed && OpB[WIDTH-1]) ? (~OpB + 1'b1) : OpB;
    sign_in  = Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
  end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  always_comb begin
    op_a_mag = OpA;
    op_b_mag = OpB;
    sign_in  = 1'b0;
  end
`endif

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StRun;
      StRun:   if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Busy     = (state_q != StIdle);
    MulWrite = (state_q == StDone);
  end

  always_comb begin
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    write_mul_d = write_mul_q;
    neg_d       = neg_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, op_a_mag};
          mplier_d = op_b_mag;
          acc_d    = '0;
          neg_d    = sign_in;
        end
      end
      StRun: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          write_mul_d = neg_q ? (~acc_d + 1'b1) : acc_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      write_mul_q <= '0;
      neg_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      write_mul_q <= write_mul_d;
      neg_q       <= neg_d;
    end
  end

  assign WriteMul = write_mul_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: expected products queued at issue, checked at MulWrite.
module tb_seq_multiplier;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [23:0] OpA, OpB;
  logic        Signed;
  logic        Busy;
  logic        MulWrite;
  logic [47:0] WriteMul;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [47:0] sb[$];

  seq_multiplier #(.WIDTH(24), .CNT_W(5)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .OpA      (OpA),
    .OpB      (OpB),
    .Signed   (Signed),
    .Busy     (Busy),
    .MulWrite (MulWrite),
    .WriteMul (WriteMul)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle Start; returns at the negedge after the sampling edge.
  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic s,
                       input logic [47:0] exp, input bit push);
    OpA = a; OpB = b; Signed = s; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    if (push) sb.push_back(exp);
    check("busy_after_start", {47'd0, Busy}, 48'd1);
  endtask

  task automatic finish_op(input string tag, input int waited);
    int c = waited;
    logic [47:0] exp;
    logic [47:0] held;
    while (!MulWrite && c < 40) begin
      OpA = 24'($urandom); OpB = 24'($urandom);
      @(negedge Clock);
      c++;
    end
    check({tag, "_strobe"}, {47'd0, MulWrite}, 48'd1);
    check({tag, "_latency"}, 48'(c), 48'd24);
    exp = (sb.size() != 0) ? sb.pop_front() : 48'hxxxxxxxxxxxx;
    check({tag, "_product"}, WriteMul, exp);
    held = WriteMul;
    @(negedge Clock);
    check({tag, "_strobe_1cyc"}, {47'd0, MulWrite}, 48'd0);
    check({tag, "_idle"}, {47'd0, Busy}, 48'd0);
    check({tag, "_held"}, WriteMul, held);
  endtask

  task automatic count_pulses(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      if (MulWrite) pulses++;
    end
    check(tag, 48'(pulses), 48'd0);
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; OpA = '0; OpB = '0; Signed = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_busy", {47'd0, Busy}, 48'd0);
    check("rst_mulwrite", {47'd0, MulWrite}, 48'd0);
    check("rst_writemul", WriteMul, 48'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    check("post_rst_busy", {47'd0, Busy}, 48'd0);

    issue(24'd5, 24'd7, 1'b0, 48'd35, 1'b1);
    finish_op("mul_5x7", 0);
    repeat (3) @(negedge Clock);
    check("hold_35", WriteMul, 48'd35);

    // Back-to-back at minimum issue interval.
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 1'b1);
    finish_op("mul_max", 0);
    issue(24'd0, 24'h123456, 1'b0, 48'd0, 1'b1);
    finish_op("mul_zero", 0);

    // Start during RUN must be ignored.
    issue(24'd3, 24'd4, 1'b0, 48'd12, 1'b1);
    repeat (9) @(negedge Clock);
    OpA = 24'd9; OpB = 24'd9; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    finish_op("ignore_start", 10);
    count_pulses("no_second_pulse", 30);

    // Reset mid-operation aborts without a write.
    issue(24'd6, 24'd6, 1'b0, 48'd36, 1'b0);
    repeat (11) @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    check("abort_busy", {47'd0, Busy}, 48'd0);
    check("abort_writemul", WriteMul, 48'd0);
    count_pulses("abort_no_pulse", 30);
    check("abort_writemul_stays", WriteMul, 48'd0);
    issue(24'd2, 24'd3, 1'b0, 48'd6, 1'b1);
    finish_op("after_abort", 0);

    // Reset and Start together: reset wins.
    OpA = 24'd7; OpB = 24'd7; Start = 1'b1; Reset_n = 1'b0;
    @(negedge Clock);
    Start = 1'b0; Reset_n = 1'b1;
    check("rst_beats_start", {47'd0, Busy}, 48'd0);

`ifdef MUL_SIGNED_EN
    issue(24'hFFFFFD, 24'd5, 1'b1, 48'hFFFFFFFFFFF1, 1'b1);
    finish_op("signed_neg", 0);
    issue(24'hFFFFFD, 24'd5, 1'b0, 48'h000004FFFFF1, 1'b1);
    finish_op("signed_off", 0);
    issue(24'h800000, 24'hFFFFFF, 1'b1, 48'h000000800000, 1'b1);
    finish_op("signed_minval", 0);
`else
    issue(24'hFFFFFD, 24'd5, 1'b1, 48'h000004FFFFF1, 1'b1);
    finish_op("signed_ignored", 0);
`endif

    check("sb_empty", 48'(sb.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
